sdram_seq_tester: RTL and testbench

SDRAM_SEQ_TESTER -- requirements
Module: sdram_seq_tester

---
 rtl/sdram_seq_tester.sv | 177 +++++++++++++++++
 tb/tb_sdram_seq_tester.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_seq_tester.sv
// Write-then-read SDRAM pattern tester: pushes WORDS incrementing words from a seed
// into the write FIFO, pops them back through the read FIFO and counts mismatches.
//
//   state | meaning
//   IDLE  | waiting for Start with Init_done
//   LOAD  | Wr_load/Rd_load held for LOAD_CYC cycles
//   WRITE | pushing Seed+idx while the write FIFO has room
//   READ  | popping and comparing, stall timer running
//   FIN   | result valid (Done sticky), Start may relaunch
module sdram_seq_tester #(
   parameter int DSIZE    = 16,
   parameter int WORDS    = 1000,
   parameter int LOAD_CYC = 4,
   parameter int TIMEOUT  = 65535
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Init_done,
   input  logic             Start,
   input  logic [DSIZE-1:0] Seed,
   input  logic             Wr_full,
   output logic             Wr_en,
   output logic [DSIZE-1:0] Wr_data,
   output logic             Wr_load,
   input  logic             Rd_empty,
   output logic             Rd_en,
   input  logic [DSIZE-1:0] Rd_data,
   output logic             Rd_load,
   output logic             Busy,
   output logic             Done,
   output logic             Pass,
   output logic             Timeout,
   output logic [15:0]      Err_cnt,
   output logic [15:0]      Err_first_idx
);

   localparam int SW = $clog2(TIMEOUT + 1);
   localparam int LW = $clog2(LOAD_CYC + 1);
   localparam logic [15:0] WORDS_W  = 16'(WORDS);
   localparam logic [15:0] LAST_IDX = 16'(WORDS - 1);
   localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, LOAD, WRITE, READ, FIN} state_t;

   state_t state, state_nx;

   logic [DSIZE-1:0] seed_q;
   logic [15:0]      wr_idx;
   logic [15:0]      rd_idx;
   logic [15:0]      cmp_idx;
   logic             cmp_pending;
   logic [SW-1:0]    stall_cnt;
   logic [LW-1:0]    load_cnt;
   logic             load_q;
   logic [15:0]      err_cnt_nx;

   logic start_ok;
   logic wr_push;
   logic rd_pop;
   logic cmp_last;
   logic mismatch;
   logic stall_hit;

   always_comb begin
      start_ok  = Start && Init_done && (state == IDLE || state == FIN);
      wr_push   = (state == WRITE) && !Wr_full && (wr_idx < WORDS_W);
      rd_pop    = (state == READ) && !Rd_empty && (rd_idx < WORDS_W);
      cmp_last  = cmp_pending && (cmp_idx == LAST_IDX);
      mismatch  = cmp_pending && (Rd_data != seed_q + DSIZE'(cmp_idx));
      stall_hit = (state == READ) && !rd_pop && (stall_cnt == STALL_LAST);
      err_cnt_nx = Err_cnt;
      if (mismatch && Err_cnt != 16'hFFFF)
         err_cnt_nx = Err_cnt + 16'd1;
   end

   always_ff @(posedge Clk) begin
      if (Rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      Wr_en    = 1'b0;
      Rd_en    = 1'b0;
      Busy     = 1'b0;
      Wr_data  = seed_q + DSIZE'(wr_idx);
      Wr_load  = load_q;
      Rd_load  = load_q;
      case (state)
         IDLE, FIN: begin
            if (start_ok)
               state_nx = LOAD;
         end
         LOAD: begin
            Busy = 1'b1;
            if (load_cnt == '0)
               state_nx = WRITE;
         end
         WRITE: begin
            Busy  = 1'b1;
            Wr_en = wr_push;
            if (wr_push && wr_idx == LAST_IDX)
               state_nx = READ;
         end
         READ: begin
            Busy  = 1'b1;
            Rd_en = rd_pop;
            if (cmp_last || stall_hit)
               state_nx = FIN;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         seed_q        <= '0;
         wr_idx        <= '0;
         rd_idx        <= '0;
         cmp_idx       <= '0;
         cmp_pending   <= 1'b0;
         stall_cnt     <= '0;
         load_cnt      <= '0;
         load_q        <= 1'b1;
         Done          <= 1'b0;
         Pass          <= 1'b0;
         Timeout       <= 1'b0;
         Err_cnt       <= '0;
         Err_first_idx <= 16'hFFFF;
      end else begin
         load_q <= (state_nx == LOAD);
         if (start_ok) begin
            seed_q        <= Seed;
            wr_idx        <= '0;
            rd_idx        <= '0;
            cmp_idx       <= '0;
            cmp_pending   <= 1'b0;
            stall_cnt     <= '0;
            load_cnt      <= LW'(LOAD_CYC - 1);
            Done          <= 1'b0;
            Pass          <= 1'b0;
            Timeout       <= 1'b0;
            Err_cnt       <= '0;
            Err_first_idx <= 16'hFFFF;
         end else begin
            if (state == LOAD && load_cnt != '0)
               load_cnt <= load_cnt - LW'(1);
            if (wr_push)
               wr_idx <= wr_idx + 16'd1;
            // read data arrives the cycle after the pop, so the compare trails by one
            cmp_pending <= rd_pop;
            if (rd_pop) begin
               rd_idx  <= rd_idx + 16'd1;
               cmp_idx <= rd_idx;
            end
            if (state == READ)
               stall_cnt <= rd_pop ? '0 : stall_cnt + SW'(1);
            if (mismatch) begin
               Err_cnt <= err_cnt_nx;
               if (Err_cnt == 16'd0)
                  Err_first_idx <= cmp_idx;
            end
            if (state == READ && cmp_last) begin
               Done <= 1'b1;
               Pass <= (err_cnt_nx == 16'd0);
            end else if (stall_hit) begin
               Done    <= 1'b1;
               Pass    <= 1'b0;
               Timeout <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sdram_seq_tester.sv
// Directed bench for sdram_seq_tester with a behavioural write/read FIFO loopback.
module tb_sdram_seq_tester;

   localparam int DSIZE    = 16;
   localparam int WORDS    = 1000;
   localparam int LOAD_CYC = 4;
   localparam int TIMEOUT  = 100;

   logic             Clk = 1'b0;
   logic             Rst;
   logic             Init_done;
   logic             Start;
   logic [DSIZE-1:0] Seed;
   logic             Wr_full;
   logic             Wr_en;
   logic [DSIZE-1:0] Wr_data;
   logic             Wr_load;
   logic             Rd_empty;
   logic             Rd_en;
   logic [DSIZE-1:0] Rd_data = '0;
   logic             Rd_load;
   logic             Busy;
   logic             Done;
   logic             Pass;
   logic             Timeout;
   logic [15:0]      Err_cnt;
   logic [15:0]      Err_first_idx;

   always #5 Clk = ~Clk;

   sdram_seq_tester #(
      .DSIZE(DSIZE), .WORDS(WORDS), .LOAD_CYC(LOAD_CYC), .TIMEOUT(TIMEOUT)
   ) u_dut (
      .Clk(Clk), .Rst(Rst), .Init_done(Init_done), .Start(Start), .Seed(Seed),
      .Wr_full(Wr_full), .Wr_en(Wr_en), .Wr_data(Wr_data), .Wr_load(Wr_load),
      .Rd_empty(Rd_empty), .Rd_en(Rd_en), .Rd_data(Rd_data), .Rd_load(Rd_load),
      .Busy(Busy), .Done(Done), .Pass(Pass), .Timeout(Timeout),
      .Err_cnt(Err_cnt), .Err_first_idx(Err_first_idx)
   );

   logic [15:0] mem [0:1023];
   logic [15:0] wcount = '0;
   logic [15:0] rcount = '0;
   logic [15:0] cur_seed = '0;
   logic [15:0] held = '0;
   logic        force_empty = 1'b0;
   int          corrupt_idx = -1;
   int          wr_seq_err = 0;
   int          stall_err = 0;
   int          cyc_cnt = 0;
   int          t_read = -1;
   int          t_done = -1;
   int          n_chk = 0;
   int          n_pass = 0;

   assign Rd_empty = force_empty || (rcount >= wcount);

   // FIFO model: write side checks the pattern, read side replays memory (optionally corrupted)
   always @(posedge Clk) begin
      cyc_cnt <= cyc_cnt + 1;
      if (Wr_load) begin
         wcount     <= '0;
         wr_seq_err <= 0;
      end else if (Wr_en) begin
         if (Wr_full || Wr_data !== 16'(cur_seed + wcount))
            wr_seq_err <= wr_seq_err + 1;
         mem[wcount[9:0]] <= Wr_data;
         wcount <= wcount + 16'd1;
      end
      if (Rd_load)
         rcount <= '0;
      else if (Rd_en) begin
         Rd_data <= mem[rcount[9:0]] ^ ((int'(rcount) == corrupt_idx) ? 16'h0001 : 16'h0000);
         rcount  <= rcount + 16'd1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic run(input logic [15:0] seed, input int corr, input bit stall,
                      output int load_len, output bit done_ok);
      bit stalled;
      cur_seed    = seed;
      corrupt_idx = corr;
      stall_err   = 0;
      t_read      = -1;
      t_done      = -1;
      Seed        = seed;
      Init_done   = 1'b1;
      Start       = 1'b1;
      tick;
      Start = 1'b0;
      check("busy_in_load", Busy, 1);
      load_len = 0;
      while (Wr_load && load_len < 20) begin
         load_len++;
         tick;
      end
      stalled = 0;
      done_ok = 0;
      for (int c = 0; c < 5000; c++) begin
         if (stall && !stalled && wcount == 16'd500) begin
            Wr_full = 1'b1;
            held    = Wr_data;
            repeat (20) begin
               tick;
               if (Wr_en || Wr_data !== held)
                  stall_err++;
            end
            Wr_full = 1'b0;
            stalled = 1;
         end
         if (wcount == 16'(WORDS) && t_read < 0)
            t_read = cyc_cnt;
         if (Done) begin
            t_done  = cyc_cnt;
            done_ok = 1;
            break;
         end
         tick;
      end
   endtask

   initial begin
      int  load_len;
      bit  done_ok;
      bit  reached;
      Rst       = 1'b1;
      Init_done = 1'b0;
      Start     = 1'b0;
      Seed      = '0;
      Wr_full   = 1'b0;
      repeat (3) tick;
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_pass", Pass, 0);
      check("rst_timeout", Timeout, 0);
      check("rst_wr_load", Wr_load, 1);
      check("rst_rd_load", Rd_load, 1);
      check("rst_wr_data", Wr_data, 0);
      check("rst_en", {Wr_en, Rd_en}, 0);
      check("rst_err_cnt", Err_cnt, 0);
      check("rst_err_first", Err_first_idx, 16'hFFFF);

      Rst = 1'b0;
      tick;
      check("loads_fall", {Wr_load, Rd_load}, 0);

      Start = 1'b1;
      tick;
      Start = 1'b0;
      tick;
      check("start_no_init_busy", Busy, 0);
      check("start_no_init_load", Wr_load, 0);

      // loopback with a 20-cycle write stall
      run(16'h0000, -1, 1, load_len, done_ok);
      check("a_load_len", load_len, LOAD_CYC);
      check("a_done", done_ok, 1);
      check("a_pass", Pass, 1);
      check("a_err_cnt", Err_cnt, 0);
      check("a_err_first", Err_first_idx, 16'hFFFF);
      check("a_timeout", Timeout, 0);
      check("a_busy", Busy, 0);
      check("a_wr_seq", wr_seq_err, 0);
      check("a_stall", stall_err, 0);
      check("a_held", held, 16'd500);
      check("a_wr_total", wcount, WORDS);
      check("a_rd_total", rcount, WORDS);
      check("a_last_word", mem[999], 16'd999);

      // corrupted read at index 37
      run(16'h0000, 37, 0, load_len, done_ok);
      check("b_done", done_ok, 1);
      check("b_err_cnt", Err_cnt, 1);
      check("b_err_first", Err_first_idx, 37);
      check("b_pass", Pass, 0);
      check("b_timeout", Timeout, 0);

      // seed wrap
      run(16'hFFFE, -1, 0, load_len, done_ok);
      check("c_done", done_ok, 1);
      check("c_w0", mem[0], 16'hFFFE);
      check("c_w1", mem[1], 16'hFFFF);
      check("c_w2", mem[2], 16'h0000);
      check("c_w3", mem[3], 16'h0001);
      check("c_wr_seq", wr_seq_err, 0);
      check("c_pass", Pass, 1);

      // read FIFO never delivers
      force_empty = 1'b1;
      run(16'h1234, -1, 0, load_len, done_ok);
      check("d_done", done_ok, 1);
      check("d_timeout", Timeout, 1);
      check("d_pass", Pass, 0);
      check("d_latency", t_done - t_read, TIMEOUT);
      check("d_no_pops", rcount, 0);
      force_empty = 1'b0;

      // reset in the middle of the write phase
      Seed  = 16'h0042;
      cur_seed = 16'h0042;
      Start = 1'b1;
      tick;
      Start = 1'b0;
      reached = 0;
      for (int c = 0; c < 500; c++) begin
         if (wcount == 16'd100) begin
            reached = 1;
            break;
         end
         tick;
      end
      check("e_reached_write", reached, 1);
      Rst = 1'b1;
      tick;
      check("e_busy", Busy, 0);
      check("e_loads", {Wr_load, Rd_load}, 2'b11);
      check("e_done", Done, 0);
      check("e_wr_en", Wr_en, 0);
      check("e_wr_data", Wr_data, 0);
      Rst = 1'b0;
      tick;
      check("e_loads_fall", {Wr_load, Rd_load}, 0);
      check("e_idle", Busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
